// File: rtl/div_n.sv
// Sequential restoring divider: one quotient bit per clock, MSB first, IDLE/CALC/FIN control.
// Optional macro DIV_SIGNED_EN adds the sgn port and truncating two's-complement division.
module div_n #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
`ifdef DIV_SIGNED_EN
  input  logic             sgn,
`endif
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             done,
  output logic             busy,
  output logic             dz
);

  // Handshake: start is taken only when busy=0 (IDLE, which includes the done
  // cycle); done pulses for one cycle and Q/R/dz hold until the next done.
  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t           state;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;
  logic [CW-1:0]    cnt;
  logic             zero;
  logic             fin_wait;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] mag1;
  logic [WIDTH-1:0] mag2;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] r_fin;

  // rem < dvs always holds, so WIDTH+1 bits are enough and diff[WIDTH] is the sign.
  assign shifted = {rem, dvd[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs};
  assign busy    = (state != IDLE);

`ifdef DIV_SIGNED_EN
  logic neg_q;
  logic neg_r;

  always_comb begin
    mag1  = (sgn && src1[WIDTH-1]) ? -src1 : src1;
    mag2  = (sgn && src2[WIDTH-1]) ? -src2 : src2;
    q_fin = neg_q ? -dvd : dvd;
    r_fin = neg_r ? -rem : rem;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (state == IDLE && start) begin
      neg_q <= sgn & (src1[WIDTH-1] ^ src2[WIDTH-1]);
      neg_r <= sgn & src1[WIDTH-1];
    end
  end
`else
  always_comb begin
    mag1  = src1;
    mag2  = src2;
    q_fin = dvd;
    r_fin = rem;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      dvd      <= '0;
      dvs      <= '0;
      rem      <= '0;
      cnt      <= '0;
      zero     <= 1'b0;
      fin_wait <= 1'b0;
      Q        <= '0;
      R        <= '0;
      dz       <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt  <= '0;
            rem  <= '0;
            dvs  <= mag2;
            zero <= (src2 == '0);
            if (src2 == '0) begin
              // Raw dividend kept for R; one wait cycle in FIN sets the zero-path latency.
              dvd      <= src1;
              fin_wait <= 1'b1;
              state    <= FIN;
            end else begin
              dvd   <= mag1;
              state <= CALC;
            end
          end
        end
        CALC: begin
          dvd <= {dvd[WIDTH-2:0], ~diff[WIDTH]};
          rem <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) state <= FIN;
        end
        FIN: begin
          if (fin_wait) begin
            fin_wait <= 1'b0;
          end else begin
            done  <= 1'b1;
            dz    <= zero;
            Q     <= zero ? '1 : q_fin;
            R     <= zero ? dvd : r_fin;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/div_n.md
DIV_N -- requirements
Module: div_n

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 Parameter CW, default $clog2(WIDTH+1), iteration counter width.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset; asynchronous and active-high.
REQ-005 Port start  input  1  request; sampled only in IDLE.
REQ-006 Port src1  input  WIDTH  dividend; sampled with accepted start.
REQ-007 Port src2  input  WIDTH  divisor; sampled with accepted start.
REQ-008 Port sgn  input  1  signed-mode select; sampled with accepted start; present only with DIV_SIGNED_EN.
REQ-009 Port Q  output  WIDTH  registered quotient.
REQ-010 Port R  output  WIDTH  registered remainder.
REQ-011 Port done  output  1  single-cycle completion pulse.
REQ-012 Port busy  output  1  high whenever state is not IDLE.
REQ-013 Port dz  output  1  divide-by-zero flag; registered with Q/R, held until next completion.

Function
REQ-014 The FSM SHALL have states IDLE, CALC, FIN.
- IDLE: start=1 -> latch operands, clear counter and partial remainder; src2!=0 -> CALC, src2==0 -> FIN with dz path.
- CALC: one restoring shift-subtract step per cycle, MSB first; after WIDTH steps -> FIN.
- FIN: load Q, R, dz; done=1 for exactly one cycle; -> IDLE.
REQ-015 Each CALC step SHALL shift {rem, dividend-MSB} left by one, subtract divisor in WIDTH+1 bits, keep the result and set quotient bit 1 if non-negative, else restore and set 0.
REQ-016 Latency: start accepted at edge k -> done high after edge k+WIDTH+1 (normal) or after edge k+2 (divisor zero).
REQ-017 start SHALL be ignored while busy=1; operand changes while busy SHALL not affect the result.
REQ-018 start high during the done cycle SHALL be accepted (state already IDLE), giving back-to-back operation with no gap.
REQ-019 Divisor zero SHALL give Q = all ones, R = src1, dz=1; otherwise dz=0.
REQ-020 Q, R, dz SHALL hold their values from done until the next done.
REQ-021 Unsigned results SHALL satisfy src1 = Q*src2 + R, R < src2.

Reset
REQ-022 rst=1 SHALL immediately force state IDLE, Q=0, R=0, done=0, busy=0, dz=0, counter and internal registers 0.
REQ-023 rst asserted mid-CALC SHALL abort the operation with no done pulse; the first start after rst release SHALL be accepted normally.

Configuration
REQ-024 Macro DIV_SIGNED_EN defined: sgn port exists; sgn=1 divides two's-complement magnitudes, negates Q if operand signs differ, gives R the dividend's sign (truncating division); MIN/-1 SHALL yield Q=MIN, R=0, dz=0; latency is unchanged.
REQ-025 DIV_SIGNED_EN undefined: no sgn port, unsigned only, no sign logic synthesised.

Verification (WIDTH=8)
REQ-026 src1=100, src2=7, start at edge k -> done after edge k+9, Q=14, R=2, dz=0.
REQ-027 src1=5, src2=0 -> done after edge k+2, Q=255, R=5, dz=1.
REQ-028 Back-to-back: 255/1 then start held in the done cycle with 3/10 -> Q=255,R=0, then Q=0,R=3 nine cycles later; start pulses while busy ignored.
REQ-029 rst pulsed at edge k+4 of 200/3 -> all outputs 0 immediately, no done; next start 200/3 -> Q=66, R=2.
REQ-030 DIV_SIGNED_EN, sgn=1: -7/2 -> Q=0xFD, R=0xFF; -128/-1 -> Q=0x80, R=0x00; same operands with sgn=0 -> Q=0x7C, R=0x01 and Q=0x00, R=0x80.
